// File: rtl/wash_phase_sequencer_if.sv
// Control, configuration and status bundle of the wash phase sequencer.
// The master side is the mode/user-input decoder and the configuration
// writer. The slave side is the sequencer itself.
interface wash_phase_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int PH_W  = 2,
  parameter int MD_W  = 2
);
  logic             start;
  logic [MD_W-1:0]  mode_sel;
  logic             pause;
  logic             abort;
  logic             cfg_we;
  logic [MD_W-1:0]  cfg_mode;
  logic [PH_W-1:0]  cfg_phase;
  logic [CNT_W-1:0] cfg_data;
  logic             busy;
  logic             paused;
  logic [PH_W-1:0]  phase_idx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] remaining;
  logic             phase_done;
  logic             cycle_done;
  logic             err;

  modport master (
    output start, mode_sel, pause, abort, cfg_we, cfg_mode, cfg_phase, cfg_data,
    input  busy, paused, phase_idx, count, remaining, phase_done, cycle_done, err
  );

  modport slave (
    input  start, mode_sel, pause, abort, cfg_we, cfg_mode, cfg_phase, cfg_data,
    output busy, paused, phase_idx, count, remaining, phase_done, cycle_done, err
  );
endinterface

// File: rtl/wash_phase_sequencer.sv
// Programmable multi-phase cycle timer for the wash controller.
// Steps through NUM_PHASES phases of the selected mode. Each phase lasts
// max(duration, 1) cycles, where the duration is taken from a
// software-writable (mode, phase) register file when the phase is entered.
module wash_phase_sequencer #(
  parameter int CNT_W      = 32,
  parameter int NUM_PHASES = 4,
  parameter int NUM_MODES  = 3,
  parameter int PH_W       = 2,
  parameter int MD_W       = 2,
  parameter int DEF_DUR    = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  wash_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // The register file spans the full index space. Only legal entries are
  // ever written or read, so the spare slots hold their reset value.
  localparam int MODE_SLOTS  = 2 ** MD_W;
  localparam int PHASE_SLOTS = 2 ** PH_W;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_DUR_L    = CNT_W'(DEF_DUR);
  localparam logic [PH_W-1:0]  PH_ZERO      = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]  PH_ONE       = {{(PH_W-1){1'b0}}, 1'b1};
  localparam logic [PH_W-1:0]  LAST_PH      = PH_W'(NUM_PHASES - 1);
  localparam logic [MD_W-1:0]  MD_ZERO      = {MD_W{1'b0}};
  localparam logic [MD_W:0]    NUM_MODES_L  = (MD_W + 1)'(NUM_MODES);
  localparam logic [PH_W:0]    NUM_PHASES_L = (PH_W + 1)'(NUM_PHASES);

  // A programmed duration of zero still occupies one cycle.
  function automatic logic [CNT_W-1:0] dur_eff(input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] r;
    if (d == CNT_ZERO) begin
      r = CNT_ONE;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_e           state_r;
  logic [MD_W-1:0]  mode_r;
  logic [PH_W-1:0]  phase_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] cur_dur_r;
  logic             busy_r;
  logic             paused_r;
  logic             phase_done_r;
  logic             cycle_done_r;
  logic             err_r;
  logic [CNT_W-1:0] dur_mem_r [MODE_SLOTS][PHASE_SLOTS];

  logic             mode_ok_s;
  logic             cfg_ok_s;
  logic             term_s;
  logic             last_s;
  logic [PH_W-1:0]  next_phase_s;
  logic [CNT_W-1:0] next_dur_s;
  logic [CNT_W-1:0] start_dur_s;

  // Decode start/config legality, terminal count and the durations of the
  // phase about to be entered (reads see the pre-write register value).
  always_comb begin
    mode_ok_s    = ({1'b0, bus.mode_sel} < NUM_MODES_L);
    cfg_ok_s     = bus.cfg_we
                   && ({1'b0, bus.cfg_mode} < NUM_MODES_L)
                   && ({1'b0, bus.cfg_phase} < NUM_PHASES_L);
    term_s       = (count_r == (cur_dur_r - CNT_ONE));
    last_s       = (phase_r == LAST_PH);
    next_phase_s = phase_r + PH_ONE;
    next_dur_s   = dur_eff(dur_mem_r[mode_r][next_phase_s]);
    start_dur_s  = dur_eff(dur_mem_r[bus.mode_sel][PH_ZERO]);
  end

  // Duration register file: reset to DEF_DUR, illegal targets are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < MODE_SLOTS; m++) begin
        for (int p = 0; p < PHASE_SLOTS; p++) begin
          dur_mem_r[m][p] <= DEF_DUR_L;
        end
      end
    end else if (cfg_ok_s) begin
      dur_mem_r[bus.cfg_mode][bus.cfg_phase] <= bus.cfg_data;
    end
  end

  // Phase sequencing FSM with registered status outputs and pulses.
  // Abort overrides everything; pause overrides terminal count. Leaving
  // PAUSED resumes counting on the same edge, so a pause held for N cycles
  // delays the phase end by exactly N cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mode_r       <= MD_ZERO;
      phase_r      <= PH_ZERO;
      count_r      <= CNT_ZERO;
      rem_r        <= CNT_ZERO;
      cur_dur_r    <= CNT_ZERO;
      busy_r       <= 1'b0;
      paused_r     <= 1'b0;
      phase_done_r <= 1'b0;
      cycle_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      phase_done_r <= 1'b0;
      cycle_done_r <= 1'b0;
      err_r        <= 1'b0;
      if (bus.abort) begin
        state_r  <= ST_IDLE;
        phase_r  <= PH_ZERO;
        count_r  <= CNT_ZERO;
        rem_r    <= CNT_ZERO;
        busy_r   <= 1'b0;
        paused_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            paused_r <= 1'b0;
            count_r  <= CNT_ZERO;
            phase_r  <= PH_ZERO;
            if (bus.start && mode_ok_s) begin
              state_r   <= ST_RUN;
              busy_r    <= 1'b1;
              mode_r    <= bus.mode_sel;
              cur_dur_r <= start_dur_s;
              rem_r     <= start_dur_s;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              rem_r   <= CNT_ZERO;
              err_r   <= bus.start;
            end
          end
          ST_RUN, ST_PAUSED: begin
            err_r <= bus.start;
            if (bus.pause) begin
              state_r  <= ST_PAUSED;
              busy_r   <= 1'b1;
              paused_r <= 1'b1;
            end else if (term_s) begin
              phase_done_r <= 1'b1;
              count_r      <= CNT_ZERO;
              paused_r     <= 1'b0;
              if (last_s) begin
                state_r      <= ST_DONE;
                busy_r       <= 1'b0;
                cycle_done_r <= 1'b1;
                rem_r        <= CNT_ZERO;
              end else begin
                state_r   <= ST_RUN;
                busy_r    <= 1'b1;
                phase_r   <= next_phase_s;
                cur_dur_r <= next_dur_s;
                rem_r     <= next_dur_s;
              end
            end else begin
              state_r  <= ST_RUN;
              busy_r   <= 1'b1;
              paused_r <= 1'b0;
              count_r  <= count_r + CNT_ONE;
              rem_r    <= rem_r - CNT_ONE;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            phase_r  <= PH_ZERO;
            count_r  <= CNT_ZERO;
            rem_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            paused_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.paused     = paused_r;
  assign bus.phase_idx  = phase_r;
  assign bus.count      = count_r;
  assign bus.remaining  = rem_r;
  assign bus.phase_done = phase_done_r;
  assign bus.cycle_done = cycle_done_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Directed self-checking bench for wash_phase_sequencer (default parameters:
// 4 phases, 3 modes, DEF_DUR 100). Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_wash_phase_sequencer;
  localparam int CNT_W = 32;
  localparam int PH_W  = 2;
  localparam int MD_W  = 2;

  logic clk = 1'b0;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  wash_phase_sequencer_if #(.CNT_W(CNT_W), .PH_W(PH_W), .MD_W(MD_W)) bus();

  wash_phase_sequencer #(
    .CNT_W(32), .NUM_PHASES(4), .NUM_MODES(3), .PH_W(2), .MD_W(2), .DEF_DUR(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.mode_sel = 2'd0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_phase = 2'd0; bus.cfg_data = 32'd0;
  endtask

  task automatic start_mode(input logic [1:0] m);
    bus.mode_sel = m; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk_cnt++;
    if ({bus.busy, bus.paused, bus.phase_done, bus.cycle_done, bus.err} !== 5'b00000)
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.busy, bus.paused, bus.phase_done, bus.cycle_done, bus.err});
    else pass_cnt++;
    chk_cnt++;
    if (bus.phase_idx !== 2'd0) $display("FAIL reset_phase got=%0d exp=0", bus.phase_idx);
    else pass_cnt++;
    chk_cnt++;
    if (bus.count !== 32'd0 || bus.remaining !== 32'd0)
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.count, bus.remaining);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_defaults();
    int pd_k [4];
    int n = 0;
    int cd_k = -1;
    logic busy_at_cd = 1'b1;
    logic [1:0] ph_at_cd = 2'd0;
    logic [1:0] ph_at_100 = 2'd0;
    for (int i = 0; i < 4; i++) pd_k[i] = -1;
    start_mode(2'd0);
    chk_cnt++;
    if (bus.busy !== 1'b1 || bus.phase_idx !== 2'd0 || bus.count !== 32'd0 || bus.remaining !== 32'd100)
      $display("FAIL defaults_entry got busy=%b ph=%0d cnt=%0d rem=%0d exp 1/0/0/100",
               bus.busy, bus.phase_idx, bus.count, bus.remaining);
    else pass_cnt++;
    for (int k = 1; k <= 402; k++) begin
      tick();
      if (bus.phase_done && n < 4) begin pd_k[n] = k; n++; end
      if (bus.cycle_done) begin cd_k = k; busy_at_cd = bus.busy; ph_at_cd = bus.phase_idx; end
      if (k == 100) ph_at_100 = bus.phase_idx;
    end
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (pd_k[i] !== 100 * (i + 1))
        $display("FAIL defaults_phase_done[%0d] got=%0d exp=%0d", i, pd_k[i], 100 * (i + 1));
      else pass_cnt++;
    end
    chk_cnt++;
    if (cd_k !== 400) $display("FAIL defaults_cycle_done got=%0d exp=400", cd_k);
    else pass_cnt++;
    chk_cnt++;
    if (busy_at_cd !== 1'b0 || ph_at_cd !== 2'd3)
      $display("FAIL defaults_done_state got busy=%b ph=%0d exp 0/3", busy_at_cd, ph_at_cd);
    else pass_cnt++;
    chk_cnt++;
    if (ph_at_100 !== 2'd1) $display("FAIL defaults_phase_step got=%0d exp=1", ph_at_100);
    else pass_cnt++;
    chk_cnt++;
    if (bus.busy !== 1'b0 || bus.phase_idx !== 2'd0 || bus.remaining !== 32'd0)
      $display("FAIL defaults_idle got busy=%b ph=%0d rem=%0d exp 0/0/0",
               bus.busy, bus.phase_idx, bus.remaining);
    else pass_cnt++;
  endtask

  task automatic test_programming();
    int vals [4] = '{5, 0, 3, 2};
    int exp_pd [4] = '{5, 6, 9, 11};
    int pd_k [4];
    int n = 0;
    int cd_k = -1;
    for (int i = 0; i < 4; i++) begin
      pd_k[i] = -1;
      bus.cfg_we = 1'b1; bus.cfg_mode = 2'd1; bus.cfg_phase = 2'(i); bus.cfg_data = 32'(vals[i]);
      tick();
    end
    bus.cfg_we = 1'b0;
    start_mode(2'd1);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) tick();
      if (k <= 4) begin
        chk_cnt++;
        if (bus.remaining !== 32'(5 - k) || bus.count !== 32'(k))
          $display("FAIL prog_remaining k=%0d got rem=%0d cnt=%0d exp rem=%0d cnt=%0d",
                   k, bus.remaining, bus.count, 5 - k, k);
        else pass_cnt++;
      end
      if (bus.phase_done && n < 4) begin pd_k[n] = k; n++; end
      if (bus.cycle_done) cd_k = k;
    end
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (pd_k[i] !== exp_pd[i])
        $display("FAIL prog_phase_done[%0d] got=%0d exp=%0d", i, pd_k[i], exp_pd[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (cd_k !== 11) $display("FAIL prog_cycle_done got=%0d exp=11", cd_k);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    int pd = -1;
    start_mode(2'd1);
    tick(); tick();
    bus.pause = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk_cnt++;
      if (bus.count !== 32'd2 || bus.paused !== 1'b1 || bus.phase_done !== 1'b0)
        $display("FAIL pause_hold j=%0d got cnt=%0d paused=%b pd=%b exp 2/1/0",
                 j, bus.count, bus.paused, bus.phase_done);
      else pass_cnt++;
    end
    bus.pause = 1'b0;
    for (int k = 10; k <= 20; k++) begin
      tick();
      if (k == 10) begin
        chk_cnt++;
        if (bus.count !== 32'd3 || bus.paused !== 1'b0)
          $display("FAIL pause_resume got cnt=%0d paused=%b exp 3/0", bus.count, bus.paused);
        else pass_cnt++;
      end
      if (bus.phase_done && pd < 0) pd = k;
    end
    chk_cnt++;
    if (pd !== 12) $display("FAIL pause_delay got=%0d exp=12", pd);
    else pass_cnt++;
    do_abort();

    start_mode(2'd1);
    tick(); tick(); tick(); tick();
    chk_cnt++;
    if (bus.count !== 32'd4) $display("FAIL pause_term_pre got=%0d exp=4", bus.count);
    else pass_cnt++;
    bus.pause = 1'b1;
    tick();
    chk_cnt++;
    if (bus.paused !== 1'b1 || bus.phase_done !== 1'b0 || bus.count !== 32'd4 || bus.phase_idx !== 2'd0)
      $display("FAIL pause_term_hold got paused=%b pd=%b cnt=%0d ph=%0d exp 1/0/4/0",
               bus.paused, bus.phase_done, bus.count, bus.phase_idx);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.phase_done !== 1'b0) $display("FAIL pause_term_hold2 got=%b exp=0", bus.phase_done);
    else pass_cnt++;
    bus.pause = 1'b0;
    tick();
    chk_cnt++;
    if (bus.phase_done !== 1'b1 || bus.phase_idx !== 2'd1 || bus.paused !== 1'b0)
      $display("FAIL pause_term_resume got pd=%b ph=%0d paused=%b exp 1/1/0",
               bus.phase_done, bus.phase_idx, bus.paused);
    else pass_cnt++;
    do_abort();
  endtask

  task automatic test_abort();
    start_mode(2'd1);
    for (int k = 1; k <= 7; k++) tick();
    chk_cnt++;
    if (bus.phase_idx !== 2'd2) $display("FAIL abort_pre_phase got=%0d exp=2", bus.phase_idx);
    else pass_cnt++;
    bus.abort = 1'b1; bus.start = 1'b1; bus.mode_sel = 2'd0;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk_cnt++;
    if ({bus.busy, bus.paused, bus.phase_done, bus.cycle_done, bus.err} !== 5'b00000
        || bus.phase_idx !== 2'd0 || bus.count !== 32'd0 || bus.remaining !== 32'd0)
      $display("FAIL abort_outputs got flags=%b ph=%0d cnt=%0d rem=%0d exp all 0",
               {bus.busy, bus.paused, bus.phase_done, bus.cycle_done, bus.err},
               bus.phase_idx, bus.count, bus.remaining);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cnt++;
      if (bus.busy !== 1'b0 || bus.phase_done !== 1'b0 || bus.cycle_done !== 1'b0)
        $display("FAIL abort_no_restart k=%0d got busy=%b pd=%b cd=%b exp 0/0/0",
                 k, bus.busy, bus.phase_done, bus.cycle_done);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors();
    start_mode(2'd3);
    chk_cnt++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL err_bad_mode got err=%b busy=%b exp 1/0", bus.err, bus.busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL err_pulse_width got err=%b busy=%b exp 0/0", bus.err, bus.busy);
    else pass_cnt++;
    start_mode(2'd1);
    tick(); tick();
    start_mode(2'd0);
    chk_cnt++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 32'd3 || bus.phase_idx !== 2'd0)
      $display("FAIL err_busy_start got err=%b busy=%b cnt=%0d ph=%0d exp 1/1/3/0",
               bus.err, bus.busy, bus.count, bus.phase_idx);
    else pass_cnt++;
    tick(); tick();
    chk_cnt++;
    if (bus.phase_done !== 1'b1 || bus.phase_idx !== 2'd1 || bus.remaining !== 32'd1 || bus.err !== 1'b0)
      $display("FAIL err_run_continues got pd=%b ph=%0d rem=%0d err=%b exp 1/1/1/0",
               bus.phase_done, bus.phase_idx, bus.remaining, bus.err);
    else pass_cnt++;
    do_abort();
  endtask

  task automatic test_live_config();
    int pd_a = -1;
    int pd_b [2] = '{-1, -1};
    int n = 0;
    logic [31:0] rem_at_200 = 32'd0;
    logic [31:0] rem_at_100 = 32'd0;
    start_mode(2'd0);
    for (int k = 1; k <= 150; k++) tick();
    chk_cnt++;
    if (bus.phase_idx !== 2'd1) $display("FAIL live_pre_phase got=%0d exp=1", bus.phase_idx);
    else pass_cnt++;
    bus.cfg_we = 1'b1; bus.cfg_mode = 2'd0; bus.cfg_phase = 2'd1; bus.cfg_data = 32'd10;
    tick();
    bus.cfg_we = 1'b0;
    for (int k = 152; k <= 402; k++) begin
      tick();
      if (bus.phase_done && pd_a < 0) begin pd_a = k; rem_at_200 = bus.remaining; end
    end
    chk_cnt++;
    if (pd_a !== 200 || rem_at_200 !== 32'd100)
      $display("FAIL live_current_phase got pd=%0d rem=%0d exp 200/100", pd_a, rem_at_200);
    else pass_cnt++;
    start_mode(2'd0);
    for (int k = 1; k <= 115; k++) begin
      tick();
      if (bus.phase_done && n < 2) begin pd_b[n] = k; n++; end
      if (k == 100) rem_at_100 = bus.remaining;
    end
    chk_cnt++;
    if (pd_b[0] !== 100 || pd_b[1] !== 110 || rem_at_100 !== 32'd10)
      $display("FAIL live_next_cycle got pd=%0d,%0d rem=%0d exp 100,110 rem=10",
               pd_b[0], pd_b[1], rem_at_100);
    else pass_cnt++;
    do_abort();
  endtask

  task automatic test_cfg_boundary();
    bus.cfg_we = 1'b1; bus.cfg_mode = 2'd2; bus.cfg_phase = 2'd0; bus.cfg_data = 32'd7;
    start_mode(2'd2);
    bus.cfg_we = 1'b0;
    chk_cnt++;
    if (bus.remaining !== 32'd100) $display("FAIL cfg_same_cycle got=%0d exp=100", bus.remaining);
    else pass_cnt++;
    do_abort();
    start_mode(2'd2);
    chk_cnt++;
    if (bus.remaining !== 32'd7) $display("FAIL cfg_later_entry got=%0d exp=7", bus.remaining);
    else pass_cnt++;
    do_abort();
    bus.cfg_we = 1'b1; bus.cfg_mode = 2'd3; bus.cfg_phase = 2'd0; bus.cfg_data = 32'd9;
    tick();
    bus.cfg_we = 1'b0;
    chk_cnt++;
    if (bus.err !== 1'b0) $display("FAIL cfg_invalid_no_err got=%b exp=0", bus.err);
    else pass_cnt++;
    start_mode(2'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if (bus.busy !== 1'b0 || bus.count !== 32'd0 || bus.remaining !== 32'd0)
      $display("FAIL rst_mid_run got busy=%b cnt=%0d rem=%0d exp 0/0/0",
               bus.busy, bus.count, bus.remaining);
    else pass_cnt++;
    start_mode(2'd1);
    chk_cnt++;
    if (bus.remaining !== 32'd100) $display("FAIL rst_restores_dur got=%0d exp=100", bus.remaining);
    else pass_cnt++;
    do_abort();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_programming();
    test_pause();
    test_abort();
    test_errors();
    test_live_config();
    test_cfg_boundary();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/wash_phase_sequencer.md
Name: wash_phase_sequencer

Overview:
- Parametrised, programmable multi-phase cycle timer for the wash controller.
- Steps automatically through NUM_PHASES phases of the selected mode, using a per-(mode, phase) duration register file that software can write.
- Adds start/abort/pause control, phase and cycle completion pulses, and remaining-time output.
- Sits between the mode/user-input decoder and the actuator FSM. The actuator FSM consumes phase_idx and the pulses.

Parameters:
- CNT_W, 32, width of duration registers and the phase counter.
- NUM_PHASES, 4, phases per cycle (≥2).
- NUM_MODES, 3, number of wash modes (≥1).
- PH_W, 2, phase index width; must satisfy 2**PH_W ≥ NUM_PHASES.
- MD_W, 2, mode index width; must satisfy 2**MD_W ≥ NUM_MODES.
- DEF_DUR, 100, reset value of every duration register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a cycle.
- mode_sel  in  MD_W  mode, sampled on start.
- pause  in  1  level; freezes the running phase.
- abort  in  1  single-cycle; returns to idle.
- cfg_we  in  1  duration register write strobe.
- cfg_mode  in  MD_W  write target mode.
- cfg_phase  in  PH_W  write target phase.
- cfg_data  in  CNT_W  duration in cycles.
- busy  out  1  high in RUN or PAUSED.
- paused  out  1  high in PAUSED.
- phase_idx  out  PH_W  current phase.
- count  out  CNT_W  elapsed cycles in the current phase.
- remaining  out  CNT_W  cycles left in the current phase.
- phase_done  out  1  one-cycle pulse at the end of each phase.
- cycle_done  out  1  one-cycle pulse at the end of the last phase.
- err  out  1  one-cycle pulse on start with an invalid mode or a busy start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state updates on the rising edge of clk.
- rst result:
  - State IDLE.
  - All outputs 0.
  - All duration registers = DEF_DUR.
  - Latched mode and current duration = 0.
- States: IDLE, RUN, PAUSED, DONE.
- Effective duration is dur_eff = max(dur, 1). A programmed 0 lasts 1 cycle.
- Duration latching:
  - On entry to a phase, the duration for (latched mode, phase) is copied into cur_dur.
  - A cfg write to the running entry affects only later entries, never the phase in progress.
- Config writes:
  - Accepted in any state when cfg_mode < NUM_MODES and cfg_phase < NUM_PHASES. Otherwise ignored, with no err.
  - A write on the same cycle as a phase entry for that same entry: the old value is latched.
- IDLE:
  - start with mode_sel < NUM_MODES → RUN next cycle, with phase_idx=0, count=0, remaining=dur_eff.
  - start with an invalid mode → stay IDLE; err pulses on the next cycle.
- RUN:
  - Each cycle: count += 1 and remaining -= 1.
  - When count == dur_eff-1, the next cycle has phase_done=1 and count=0.
  - If not the last phase: phase_idx += 1, then latch the new duration.
  - If the last phase: go to DONE, with phase_idx held at NUM_PHASES-1.
  - A phase of duration D therefore occupies exactly D cycles.
- PAUSED:
  - pause=1 in RUN → PAUSED next cycle. count and remaining freeze; no pulses.
  - pause has priority over terminal count on the same cycle: that phase does not complete.
  - pause=0 → RUN next cycle, resuming from the frozen count.
- DONE: a single cycle with cycle_done=1 (coincident with the final phase_done cycle), busy=0, then IDLE. count, phase_idx and remaining are cleared on entry to IDLE.
- abort:
  - From any state, → IDLE next cycle. busy, count, phase_idx and remaining are cleared.
  - No phase_done or cycle_done pulse.
  - abort wins over start, pause and terminal count on the same cycle.
- start while busy: ignored and err pulses. start in DONE is accepted as from IDLE.
- Counter widths: CNT_W arithmetic; no wrap is possible because count < dur_eff ≤ 2**CNT_W-1.
- rst mid-operation: same result as power-on reset, including restoring the duration registers to DEF_DUR.

Test Plan:
- Defaults: rst, start with mode 0 → phases 0..3 each 100 cycles, phase_done at cycles 100/200/300/400 after RUN entry, cycle_done with the 4th phase_done, busy low after.
- Programming: write mode 1 durations {5,0,3,2}, start mode 1 → phase lengths 5,1,3,2 cycles; remaining counts 5..1 in phase 0.
- Pause: mode 1 as above; assert pause at count=2 of phase 0 for 7 cycles → count holds at 2; phase_done arrives 7 cycles later than unpaused. Pause coincident with count=4 → no phase_done until resume.
- Abort: abort during phase 2 with simultaneous start → IDLE, all outputs 0, no pulses, no restart.
- Errors: start with mode_sel=3 (NUM_MODES=3) → err pulse, stays IDLE. start while RUN → err, run continues unchanged.
- Live config: during phase 1 of mode 0, write mode 0 phase 1 = 10 → current phase still 100 cycles; the next cycle's phase 1 is 10 cycles.
